fc_module: RTL
==============

// Module: fc_module
// PURPOSE
//   Fully-connected classifier stage directly downstream of pool_module.
//   Captures the 3x3x3 pooled feature bus (pool_lin) on start and computes N_OUT class
//   scores: score[c] = sum_i feat[i]*W[c*N_IN+i], with feat unsigned and W signed.
//   Uses one time-shared MAC and reads weights from an external synchronous ROM.
//   Reports all scores plus the argmax class index.
// PARAMETERS
//   N_IN   27  feature elements (3*3*3), each 8-bit unsigned
//   N_OUT  10  number of classes / output scores
//   ACC_W  24  signed accumulator and score width (worst case needs 21 bits)
//   AW     9   weight ROM address width, must satisfy 2**AW >= N_IN*N_OUT
//   CW     4   class index width, must satisfy 2**CW >= N_OUT
// PORTS
//   clk      in   1            single clock, rising edge
//   rst_n    in   1            asynchronous active-low reset
//   start    in   1            1-cycle request; accepted only in IDLE
//   pool_lin in   N_IN*8       feature i = pool_lin[i*8+:8], unsigned; sampled on the accept edge
//   w_en     out  1            ROM read enable
//   w_addr   out  AW           ROM address = c*N_IN + i
//   w_data   in   8            signed weight; valid the cycle after the edge that registers w_addr (1-cycle ROM)
//   busy     out  1            high from the accept edge until done
//   done     out  1            1-cycle pulse when scores and class are final
//   score_o  out  N_OUT*ACC_W  score c = score_o[c*ACC_W+:ACC_W], two's complement
//   class_o  out  CW           index of the maximum score
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy, done, w_en = 0; w_addr = 0;
//     all scores = 0; class_o = 0; feature register = 0.
//   FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//   - IDLE: start=1 at edge 0 latches pool_lin, sets busy=1 and state=RUN.
//     start=0 leaves the FSM in IDLE.
//   - RUN: the registered address counter k = 0 .. N_IN*N_OUT-1 drives w_addr=k and w_en=1
//     in the cycle after edge k.
//   - DRAIN: w_en=0. The FSM waits for the last two MAC stages to complete.
//   - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
//   Pipeline timing:
//   - the product for address k = {1'b0,feat[i]} * $signed(w_data) is added at edge k+2;
//   - the accumulator is cleared (loaded with the product) when i==0;
//   - score[c] is written when i==N_IN-1.
//   Latency: done is high in the cycle after edge N_IN*N_OUT+2 (272 with the defaults),
//     counted from the accept edge 0.
//   Argmax:
//   - updated as each score is written, using a signed compare;
//   - a strictly greater score replaces the current best, so ties keep the lowest index;
//   - class 0 always initialises the best.
//   Arithmetic:
//   - the product is 17-bit signed and is sign-extended to ACC_W;
//   - no saturation (the parameter rule guarantees no overflow).
//   Outputs: score_o and class_o keep their values from done until the next accepted start.
//     At the next accepted start they are overwritten progressively, not cleared.
//   Boundaries:
//   - start while busy or in DONE is ignored; pool_lin changes after the accept edge are ignored;
//   - back-to-back operation: start asserted in the cycle after the done cycle is accepted;
//   - rst_n low mid-operation aborts immediately to reset values, and no done is produced;
//   - w_addr never exceeds N_IN*N_OUT-1.
// TESTING
//   1. All features = 1, W[c*27+i] = c-5 -> score[c] = 27*(c-5), i.e. -135 .. 108; class_o = 9.
//   2. Feature 0 = 255, others 0, W[c*27] = -128 for all c -> every score = -32640;
//      class_o = 0 (tie rule).
//   3. All features = 255, all W = 127 -> every score = 874395 (no overflow); class_o = 0.
//      All W = -128 -> every score = -881280.
//   4. Latency and handshake: start at edge 0.
//      - Check that w_addr steps 0..269 with w_en=1.
//      - Check that done is a single pulse after edge 272, with busy high from edge 0 to edge 272.
//      - A start pulse at edge 100 has no effect.
//   5. Abort: pull rst_n low at edge 150.
//      - All outputs reach reset values with no clock edge required; no done pulse.
//      - A following run with test-1 data gives test-1 results.
//   6. Back-to-back: assert start in the cycle after done, with new features.
//      - The second run must match a golden model.
//      - Run 100 random vectors through the pool_module -> fc_module chain against golden scores.

Source files
------------

// File: rtl/fc_module_if.sv
// fc_module_if: request/ROM/result bundle between the classifier stage and its
// environment.
//   start    - 1-cycle request pulse
//   pool_lin - 3x3x3 pooled feature bus, 8-bit unsigned per element
//   w_en     - weight ROM read enable
//   w_addr   - weight ROM address (c*N_IN + i)
//   w_data   - signed weight, valid one cycle after the registered address
//   busy     - operation in flight
//   done     - 1-cycle completion pulse
//   score_o  - N_OUT packed two's complement scores
//   class_o  - argmax class index
// master: the environment side. slave: the fc_module side.
interface fc_module_if #(
  parameter int N_IN  = 27,
  parameter int N_OUT = 10,
  parameter int ACC_W = 24,
  parameter int AW    = 9,
  parameter int CW    = 4
);
  logic                    start;
  logic [N_IN*8-1:0]       pool_lin;
  logic                    w_en;
  logic [AW-1:0]           w_addr;
  logic signed [7:0]       w_data;
  logic                    busy;
  logic                    done;
  logic [N_OUT*ACC_W-1:0]  score_o;
  logic [CW-1:0]           class_o;

  modport master (
    output start, pool_lin, w_data,
    input  w_en, w_addr, busy, done, score_o, class_o
  );

  modport slave (
    input  start, pool_lin, w_data,
    output w_en, w_addr, busy, done, score_o, class_o
  );
endinterface

// File: rtl/fc_module.sv
// fc_module: fully-connected classifier stage.
// Latches the pooled feature bus on an accepted start and computes
//   score[c] = sum_i feat[i] * W[c*N_IN+i]   (feat unsigned, W signed)
// with one time-shared MAC fed from an external 1-cycle synchronous weight ROM,
// then reports all scores and the argmax class.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - fc_module_if slave (start/pool_lin in, ROM port, busy/done/results out)
module fc_module #(
  parameter int N_IN  = 27,
  parameter int N_OUT = 10,
  parameter int ACC_W = 24,
  parameter int AW    = 9,
  parameter int CW    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fc_module_if.slave   bus
);

  localparam int            IW   = $clog2(N_IN);
  localparam logic [AW-1:0] LAST = AW'(N_IN*N_OUT-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                          r_state;
  logic [N_IN*8-1:0]               r_feat;
  logic                            r_w_en;
  logic [AW-1:0]                   r_w_addr;
  logic [IW-1:0]                   r_i;      // feature index of r_w_addr
  logic [CW-1:0]                   r_c;      // class index of r_w_addr
  logic                            r_drain;
  logic                            r_busy;
  logic                            r_done;

  // MAC stage: tags the ROM data that arrives in the following cycle
  logic                            r_v1;
  logic [IW-1:0]                   r_i1;
  logic [CW-1:0]                   r_c1;
  logic signed [ACC_W-1:0]         r_acc;
  logic [N_OUT-1:0][ACC_W-1:0]     r_score;
  logic signed [ACC_W-1:0]         r_best;
  logic [CW-1:0]                   r_class;

  logic [7:0]                      w_feat;
  logic signed [16:0]              w_prod;
  logic signed [ACC_W-1:0]         w_prod_x;
  logic signed [ACC_W-1:0]         w_sum;

  assign w_feat   = r_feat[{r_i1, 3'b000} +: 8];
  // zero-extend the feature so the multiply is signed x signed
  assign w_prod   = $signed({1'b0, w_feat}) * bus.w_data;
  assign w_prod_x = {{(ACC_W-17){w_prod[16]}}, w_prod};
  // first term of a class reloads the accumulator instead of clearing it
  assign w_sum    = (r_i1 == '0) ? w_prod_x : r_acc + w_prod_x;

  // control FSM, address generator and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_feat   <= '0;
      r_w_en   <= 1'b0;
      r_w_addr <= '0;
      r_i      <= '0;
      r_c      <= '0;
      r_drain  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_feat   <= bus.pool_lin;
            r_busy   <= 1'b1;
            r_w_en   <= 1'b1;
            r_w_addr <= '0;
            r_i      <= '0;
            r_c      <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (r_w_addr == LAST) begin
            // address holds at the last entry; it never runs past the table
            r_w_en  <= 1'b0;
            r_drain <= 1'b0;
            r_state <= DRAIN;
          end else begin
            r_w_addr <= r_w_addr + 1'b1;
            if (r_i == IW'(N_IN-1)) begin
              r_i <= '0;
              r_c <= r_c + 1'b1;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end
        end
        DRAIN: begin
          // two edges: ROM read of the last address, then its accumulate
          if (r_drain) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_drain <= 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // MAC, score write-back and running argmax
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_i1    <= '0;
      r_c1    <= '0;
      r_acc   <= '0;
      r_score <= '0;
      r_best  <= '0;
      r_class <= '0;
    end else begin
      r_v1 <= r_w_en;
      r_i1 <= r_i;
      r_c1 <= r_c;
      if (r_v1) begin
        r_acc <= w_sum;
        if (r_i1 == IW'(N_IN-1)) begin
          r_score[r_c1] <= w_sum;
          // class 0 seeds the best; only a strictly larger score displaces it
          if (r_c1 == '0 || w_sum > r_best) begin
            r_best  <= w_sum;
            r_class <= r_c1;
          end
        end
      end
    end
  end

  assign bus.w_en    = r_w_en;
  assign bus.w_addr  = r_w_addr;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.score_o = r_score;
  assign bus.class_o = r_class;

endmodule
